// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] COL_RST = 4'b1110;
  localparam int         KEY_W   = 4;

  // Position of the single low bit in the column drive.
  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    case (c)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Lowest-index low row; rows are active-low.
  function automatic logic [1:0] low_row(input logic [3:0] f);
    logic [1:0] r;
    r = 2'd0;
    if (!f[0])      r = 2'd0;
    else if (!f[1]) r = 2'd1;
    else if (!f[2]) r = 2'd2;
    else if (!f[3]) r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/module_scan_timer.sv
// Free-running scan tick: one-cycle pulse every SCAN_TICKS clk cycles.
// Latency: first pulse in the SCAN_TICKS-th cycle after reset release.
// Backpressure: none; the tick is never stalled.
module module_scan_timer #(
  parameter int SCAN_TICKS = 27000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_TICKS - 1);

  logic [CW-1:0] cnt;

  // Modulo-SCAN_TICKS cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 matrix keypad scanner with per-tick debounce and a one-deep key holding register.
// Latency: 2-cycle input synchronizer, then decisions only on scan ticks.
// Backpressure: key_valid/key_ack handshake; an unacked key is overwritten and flagged by overrun.
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS  = 27000,
  parameter int DEB_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       fil,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             overrun
);

  localparam int            SW    = $clog2(DEB_SAMPLES);
  localparam logic [SW-1:0] SLAST = SW'(DEB_SAMPLES - 1);

  logic [3:0]    fil_m;
  logic [3:0]    fil_s;
  logic          tick;
  state_t        state;
  logic [1:0]    row;
  logic [SW-1:0] samples;
  logic [1:0]    cidx;
  logic          row_low;
  logic          all_up;

  module_scan_timer #(.SCAN_TICKS(SCAN_TICKS)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign cidx    = col_index(col);
  assign row_low = ~fil_s[row];
  assign all_up  = (fil_s == 4'hF);

  // Two-flop synchronizer; idle (pulled-up) value during reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fil_m <= 4'hF;
      fil_s <= 4'hF;
    end else begin
      fil_m <= fil;
      fil_s <= fil_m;
    end
  end

  // Scan/debounce FSM with the key holding register and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col       <= COL_RST;
      row       <= 2'd0;
      samples   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // Ack consumes the key; a confirmation below in the same cycle wins
      if (key_valid && key_ack) key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (all_up) begin
              col <= {col[2:0], col[3]};
            end else begin
              row     <= low_row(fil_s);
              samples <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (row_low) begin
              if (samples == SLAST) begin
                key_code  <= {row, cidx};
                key_valid <= 1'b1;
                overrun   <= key_valid & ~key_ack;
                state     <= HOLD;
              end else begin
                samples <= samples + 1'b1;
              end
            end else begin
              // Bounce: rescan the same column
              state <= SCAN;
            end
          end
          HOLD: begin
            if (all_up) begin
              samples <= '0;
              state   <= RELEASE;
            end
          end
          RELEASE: begin
            if (all_up) begin
              if (samples == SLAST) begin
                col   <= {col[2:0], col[3]};
                state <= SCAN;
              end else begin
                samples <= samples + 1'b1;
              end
            end else begin
              state <= HOLD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
